adpcm_rom_cache: RTL and testbench
==================================

// Module: adpcm_rom_cache
// PURPOSE
// - Upstream feeder of the OKIM6295 ADPCM core: serves its byte-wide sample-ROM port from burst-oriented SDRAM.
// - Holds one line of BURST_LENGTH memory words and answers hits in 1 cycle.
// - On a miss, fetches the whole aligned line in one burst.
// - Sits between the sound ROM arbiter port of the memory subsystem and OKIM6295 io_rom_*.
// PARAMETERS
// - ROM_ADDR_WIDTH  18         byte address width of the ADPCM ROM port
// - MEM_ADDR_WIDTH  25         byte address width of the SDRAM port
// - MEM_DATA_WIDTH  16         SDRAM word width; multiple of 8
// - BURST_LENGTH    4          words per burst; power of 2
// - BASE_ADDR       25'h0      SDRAM byte offset of the ADPCM ROM region
// PORTS
// - clock          in   1                clock; all logic on rising edge
// - reset          in   1                synchronous, active-high
// - io_rom_addr    in   ROM_ADDR_WIDTH   byte address requested by OKIM6295
// - io_rom_dout    out  8                byte at io_rom_addr
// - io_rom_valid   out  1                io_rom_dout is valid for the current io_rom_addr
// - io_mem_rd      out  1                burst read request
// - io_mem_addr    out  MEM_ADDR_WIDTH   line-aligned byte address of the burst
// - io_mem_waitReq in   1                request not accepted this cycle
// - io_mem_valid   in   1                burst data word valid
// - io_mem_dout    in   MEM_DATA_WIDTH   burst data word
// BEHAVIOUR
// - Derived constants:
//   - LINE_BYTES = BURST_LENGTH*MEM_DATA_WIDTH/8 (8 at defaults).
//   - tag = io_rom_addr[ROM_ADDR_WIDTH-1:log2(LINE_BYTES)].
//   - offset = the remaining low bits.
// - Reset:
//   - io_rom_valid=0, io_rom_dout=0, io_mem_rd=0, io_mem_addr=0.
//   - Line invalid, state IDLE.
// - Valid gating:
//   - io_rom_valid = validReg && (io_rom_addr == addrReg).
//   - The gate is combinational, so valid drops in the same cycle the address changes and a stale byte is never flagged.
// - States:
//   - IDLE: latch addrReg <= io_rom_addr every cycle.
//     - Tag hit on a valid line: next cycle dout <= line byte, validReg=1, stay IDLE.
//     - Miss: validReg=0, go REQ.
//   - REQ: io_mem_rd=1, io_mem_addr = BASE_ADDR + {tag, offset=0}.
//     - Held stable while io_mem_waitReq=1.
//     - First cycle with io_mem_waitReq=0: go FILL, word counter=0.
//   - FILL: on each io_mem_valid, write word to line[counter] and increment the counter.
//     - After word BURST_LENGTH-1: line tag <= fetched tag, line valid=1, go IDLE.
//     - The hit is then re-evaluated against the current io_rom_addr.
// - Byte order: little-endian within a word.
//   - Byte k of a word = dout[8k+7:8k].
//   - Line byte index = word*(MEM_DATA_WIDTH/8)+k.
// - Latency:
//   - Hit: 1 cycle from address change to io_rom_valid.
//   - Miss: 1 (detect) + REQ wait + BURST_LENGTH data beats + 1 (lookup).
// - Address change during REQ/FILL:
//   - The burst always completes; a burst is never aborted.
//   - The new address is then serviced from IDLE, which may issue a second burst.
// - io_mem_valid outside FILL is ignored. The memory controller shares this reset, so no burst is outstanding after reset.
// - Reset mid-FILL: line invalidated, partial data discarded, state IDLE.
// - Address wrap: max address 2^ROM_ADDR_WIDTH-1 maps to the last line; there is no crossing past the region end.
// - Line write and lookup never occur in the same cycle; the lookup happens only in IDLE.
// STRUCTURE
// - Shared cave package:
//   - state enum {IDLE, REQ, FILL}.
//   - ADPCM_ROM_ADDR_WIDTH, ADPCM_ROM_BASE constants.
// - Local: line storage as a BURST_LENGTH x MEM_DATA_WIDTH register array. No sub-module.
// - Top level: OKIM6295.io_rom_* connects directly to io_rom_*; io_mem_* connects to the SDRAM arbiter sound port.
// TESTING
// 1. Cold miss:
//    - Stimulus: after reset, addr=0x00005; memory returns 0x1100,0x3322,0x5544,0x7766.
//    - Required: io_mem_addr=BASE+0x0, one rd accepted; dout=0x55 with valid 1 cycle after the last beat.
// 2. Hit:
//    - Stimulus: addr changes 0x00005->0x00007.
//    - Required: valid=0 in the change cycle; next cycle dout=0x77, valid=1; no io_mem_rd.
// 3. Wait request:
//    - Stimulus: miss with waitReq=1 for 5 cycles.
//    - Required: io_mem_rd and io_mem_addr held constant for 6 cycles; exactly one burst.
// 4. Address change during FILL:
//    - Stimulus: addr 0x00008->0x00100 after beat 1.
//    - Required: burst finishes; second burst at BASE+0x100; valid only for 0x00100 data.
// 5. Reset mid-FILL:
//    - Stimulus: assert reset after beat 2; then addr=0x00009.
//    - Required: all outputs 0 in the reset cycle; full new burst at BASE+0x8; no stale hit.
// 6. Top address:
//    - Stimulus: addr=0x3FFFF, BASE=0x100000.
//    - Required: io_mem_addr=0x13FFF8; dout=byte 7 of the line.

Source files
------------

// File: rtl/adpcm_rom_cache_pkg.sv
// Shared definitions for the ADPCM sample-ROM line cache: controller states and ROM region defaults.
package adpcm_rom_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL
   } state_t;

   localparam int          ADPCM_ROM_ADDR_WIDTH = 18;
   localparam logic [24:0] ADPCM_ROM_BASE       = 25'h0;

endpackage

// File: rtl/adpcm_rom_cache_if.sv
// Sample-ROM side (OKIM6295 io_rom_*) and SDRAM burst side (io_mem_*) of the cache.
// slave is the cache's view; master is the view of whatever surrounds it.
interface adpcm_rom_cache_if #(
   parameter int ROM_ADDR_WIDTH = 18,
   parameter int MEM_ADDR_WIDTH = 25,
   parameter int MEM_DATA_WIDTH = 16
);
   logic [ROM_ADDR_WIDTH-1:0] rom_addr;
   logic [7:0]                rom_dout;
   logic                      rom_valid;
   logic                      mem_rd;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic                      mem_waitReq;
   logic                      mem_valid;
   logic [MEM_DATA_WIDTH-1:0] mem_dout;

   modport slave (
      input  rom_addr,
      output rom_dout, rom_valid,
      output mem_rd, mem_addr,
      input  mem_waitReq, mem_valid, mem_dout
   );

   modport master (
      output rom_addr,
      input  rom_dout, rom_valid,
      input  mem_rd, mem_addr,
      output mem_waitReq, mem_valid, mem_dout
   );
endinterface

// File: rtl/adpcm_rom_cache.sv
// One-line cache serving the byte-wide ADPCM ROM port from burst SDRAM.
// Hits answer one cycle after the address; a miss refills the whole aligned line in one burst.
module adpcm_rom_cache
   import adpcm_rom_cache_pkg::*;
#(
   parameter int                  ROM_ADDR_WIDTH = ADPCM_ROM_ADDR_WIDTH,
   parameter int                  MEM_ADDR_WIDTH = 25,
   parameter int                  MEM_DATA_WIDTH = 16,
   parameter int                  BURST_LENGTH   = 4,
   parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = MEM_ADDR_WIDTH'(ADPCM_ROM_BASE)
) (
   input  logic              clock,
   input  logic              reset,
   adpcm_rom_cache_if.slave  io
);

   localparam int BPW        = MEM_DATA_WIDTH / 8;
   localparam int LINE_BYTES = BURST_LENGTH * BPW;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int TAG_W      = ROM_ADDR_WIDTH - OFF_W;
   localparam int CNT_W      = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

   state_t                    state_q, state_d;
   logic [ROM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [TAG_W-1:0]          tag_q, tag_d, fetchTag_q, fetchTag_d;
   logic                      lineValid_q, lineValid_d;
   logic                      valid_q, valid_d;
   logic [7:0]                dout_q, dout_d;
   logic                      memRd_q, memRd_d;
   logic [MEM_ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [MEM_DATA_WIDTH-1:0] line_q [BURST_LENGTH];
   logic [MEM_DATA_WIDTH-1:0] line_d [BURST_LENGTH];

   logic [LINE_BYTES*8-1:0]   lineFlat;
   logic [TAG_W-1:0]          reqTag;
   logic [OFF_W-1:0]          reqOff;
   logic                      hit;

   assign reqTag = io.rom_addr[ROM_ADDR_WIDTH-1:OFF_W];
   assign reqOff = io.rom_addr[OFF_W-1:0];
   assign hit    = lineValid_q && (tag_q == reqTag);

   // Word 0 in the low bits gives little-endian byte numbering across the line.
   always_comb begin
      lineFlat = '0;
      for (int i = 0; i < BURST_LENGTH; i++)
         lineFlat[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = line_q[i];
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      tag_d       = tag_q;
      fetchTag_d  = fetchTag_q;
      lineValid_d = lineValid_q;
      valid_d     = valid_q;
      dout_d      = dout_q;
      memRd_d     = memRd_q;
      memAddr_d   = memAddr_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      case (state_q)
         IDLE: begin
            addr_d = io.rom_addr;
            if (hit) begin
               dout_d  = lineFlat[{reqOff, 3'b000} +: 8];
               valid_d = 1'b1;
            end else begin
               valid_d    = 1'b0;
               fetchTag_d = reqTag;
               memRd_d    = 1'b1;
               memAddr_d  = BASE_ADDR + MEM_ADDR_WIDTH'({reqTag, {OFF_W{1'b0}}});
               state_d    = REQ;
            end
         end
         REQ: begin
            if (!io.mem_waitReq) begin
               memRd_d = 1'b0;
               cnt_d   = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            if (io.mem_valid) begin
               line_d[cnt_q] = io.mem_dout;
               cnt_d         = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BURST_LENGTH - 1)) begin
                  tag_d       = fetchTag_q;
                  lineValid_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         tag_q       <= '0;
         fetchTag_q  <= '0;
         lineValid_q <= 1'b0;
         valid_q     <= 1'b0;
         dout_q      <= '0;
         memRd_q     <= 1'b0;
         memAddr_q   <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < BURST_LENGTH; i++) line_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         tag_q       <= tag_d;
         fetchTag_q  <= fetchTag_d;
         lineValid_q <= lineValid_d;
         valid_q     <= valid_d;
         dout_q      <= dout_d;
         memRd_q     <= memRd_d;
         memAddr_q   <= memAddr_d;
         cnt_q       <= cnt_d;
         line_q      <= line_d;
      end
   end

   // The address compare is combinational so a changed address never sees a stale valid.
   assign io.rom_valid = valid_q && (io.rom_addr == addr_q);
   assign io.rom_dout  = dout_q;
   assign io.mem_rd    = memRd_q;
   assign io.mem_addr  = memAddr_q;

endmodule

// File: tb/tb_adpcm_rom_cache.sv
// Directed bench for adpcm_rom_cache with BASE_ADDR at 0x100000.
module tb_adpcm_rom_cache;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   rdCount = 0;

   adpcm_rom_cache_if #(.ROM_ADDR_WIDTH(18), .MEM_ADDR_WIDTH(25), .MEM_DATA_WIDTH(16)) io ();

   adpcm_rom_cache #(
      .ROM_ADDR_WIDTH(18),
      .MEM_ADDR_WIDTH(25),
      .MEM_DATA_WIDTH(16),
      .BURST_LENGTH  (4),
      .BASE_ADDR     (25'h100000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .io   (io)
   );

   always #5 clock = ~clock;

   // Accepted burst requests.
   always @(posedge clock)
      if (!reset && io.mem_rd && !io.mem_waitReq) rdCount++;

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for the request, applies waitReq stalls, then returns the four beats.
   // Optional address change or reset after a given beat (-1 disables).
   task automatic fetch(input logic [24:0] exp_addr, input int waits,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3,
                        input int chg_beat, input logic [17:0] chg_addr,
                        input int rst_beat);
      logic [15:0] w [4];
      int n;
      w = '{w0, w1, w2, w3};
      n = 0;
      while (!io.mem_rd && n < 10) begin
         step();
         n++;
      end
      chk("rd_seen", 32'(io.mem_rd), 32'd1);
      chk("mem_addr", 32'(io.mem_addr), 32'(exp_addr));
      io.mem_waitReq = (waits > 0);
      for (int i = 0; i < waits; i++) begin
         step();
         chk("rd_held", 32'(io.mem_rd), 32'd1);
         chk("addr_held", 32'(io.mem_addr), 32'(exp_addr));
      end
      io.mem_waitReq = 1'b0;
      step();
      chk("rd_drop", 32'(io.mem_rd), 32'd0);
      for (int b = 0; b < 4; b++) begin
         io.mem_valid = 1'b1;
         io.mem_dout  = w[b];
         step();
         io.mem_valid = 1'b0;
         if (b == chg_beat) io.rom_addr = chg_addr;
         if (b == rst_beat) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("rst_valid", 32'(io.rom_valid), 32'd0);
            chk("rst_dout", 32'(io.rom_dout), 32'd0);
            chk("rst_rd", 32'(io.mem_rd), 32'd0);
            chk("rst_maddr", 32'(io.mem_addr), 32'd0);
            return;
         end
      end
   endtask

   task automatic wait_valid(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      while (!io.rom_valid && n < 4) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 32'(io.rom_valid), 32'd1);
      chk({tag, "_dout"}, 32'(io.rom_dout), 32'(exp));
   endtask

   initial begin
      io.rom_addr    = '0;
      io.mem_waitReq = 1'b0;
      io.mem_valid   = 1'b0;
      io.mem_dout    = '0;
      @(negedge clock);
      step();
      chk("reset_valid", 32'(io.rom_valid), 32'd0);
      chk("reset_dout", 32'(io.rom_dout), 32'd0);
      chk("reset_rd", 32'(io.mem_rd), 32'd0);
      chk("reset_maddr", 32'(io.mem_addr), 32'd0);
      reset = 1'b0;

      // Cold miss
      io.rom_addr = 18'h00005;
      fetch(25'h100000, 0, 16'h1100, 16'h3322, 16'h5544, 16'h7766, -1, 18'h0, -1);
      wait_valid("cold", 8'h55);
      chk("cold_rdcount", 32'(rdCount), 32'd1);

      // Hit
      io.rom_addr = 18'h00007;
      #1;
      chk("hit_chg_valid", 32'(io.rom_valid), 32'd0);
      step();
      chk("hit_valid", 32'(io.rom_valid), 32'd1);
      chk("hit_dout", 32'(io.rom_dout), 32'h77);
      chk("hit_rd", 32'(io.mem_rd), 32'd0);
      chk("hit_rdcount", 32'(rdCount), 32'd1);

      // Wait request for 5 cycles
      io.rom_addr = 18'h00010;
      fetch(25'h100010, 5, 16'hB1B0, 16'hB3B2, 16'hB5B4, 16'hB7B6, -1, 18'h0, -1);
      wait_valid("wait", 8'hB0);
      chk("wait_rdcount", 32'(rdCount), 32'd2);

      // Address change during FILL
      io.rom_addr = 18'h00008;
      fetch(25'h100008, 0, 16'hC1C0, 16'hC3C2, 16'hC5C4, 16'hC7C6, 1, 18'h00100, -1);
      chk("chg_no_stale", 32'(io.rom_valid), 32'd0);
      fetch(25'h100100, 0, 16'hD1D0, 16'hD3D2, 16'hD5D4, 16'hD7D6, -1, 18'h0, -1);
      wait_valid("chg", 8'hD0);
      chk("chg_rdcount", 32'(rdCount), 32'd4);

      // Reset mid-FILL, then a fresh miss on the same line
      io.rom_addr = 18'h0000A;
      fetch(25'h100008, 0, 16'hE1E0, 16'hE3E2, 16'hE5E4, 16'hE7E6, -1, 18'h0, 2);
      io.rom_addr = 18'h00009;
      #1;
      chk("rst_no_hit", 32'(io.rom_valid), 32'd0);
      fetch(25'h100008, 0, 16'hF1F0, 16'hF3F2, 16'hF5F4, 16'hF7F6, -1, 18'h0, -1);
      wait_valid("rst", 8'hF1);
      chk("rst_rdcount", 32'(rdCount), 32'd6);

      // Top address
      io.rom_addr = 18'h3FFFF;
      fetch(25'h13FFF8, 0, 16'h1100, 16'h3322, 16'h5544, 16'h7766, -1, 18'h0, -1);
      wait_valid("top", 8'h77);
      chk("top_rdcount", 32'(rdCount), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
